// File: rtl/sg1_uart_pkg.sv
// Shared UART definitions for the receiver and the future transmitter.
package sg1_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } uart_state_e;

  localparam int UART_DBITS   = 8;
  localparam int BAUD_DIV_DEF = 868;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous bit with selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232_rx.sv
// UART receiver: start, 8 data bits MSB first, XOR parity, one stop bit.
//   state    | meaning
//   S_IDLE   | line idle, waiting for a falling edge
//   S_START  | timing to mid start bit, rejects glitches
//   S_DATA   | sampling the 8 data bits
//   S_PARITY | sampling the parity bit
//   S_STOP   | sampling the stop bit, delivers the byte
//   S_BREAK  | stop was low, waiting for the line to return high
module rs232_rx
  import sg1_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_busy
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(UART_DBITS);

  uart_state_e state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [CW-1:0] bit_cnt, bit_nxt;
  logic [UART_DBITS-1:0] shift_reg, shift_nxt, data_nxt;
  logic par_err, par_err_nxt, perr_nxt, ferr_nxt, vld_nxt;
  logic rx_sync, rx_prev, fall, expire;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .d       (uart_rx),
    .q       (rx_sync)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) rx_prev <= 1'b1;
    else        rx_prev <= rx_sync;
  end

  assign fall    = rx_prev & ~rx_sync;
  assign expire  = (baud_cnt == '0);
  assign rx_busy = (state != S_IDLE);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_err   <= 1'b0;
      rx_data   <= '0;
      rx_perr   <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_vld    <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      par_err   <= par_err_nxt;
      rx_data   <= data_nxt;
      rx_perr   <= perr_nxt;
      rx_ferr   <= ferr_nxt;
      rx_vld    <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud_cnt;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift_reg;
    par_err_nxt = par_err;
    data_nxt    = rx_data;
    perr_nxt    = rx_perr;
    ferr_nxt    = rx_ferr;
    vld_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          baud_nxt  = BW'(HALF_DIV - 1);
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (!expire) begin
          baud_nxt = baud_cnt - BW'(1);
        end else if (!rx_sync) begin
          baud_nxt  = BW'(BAUD_DIV - 1);
          bit_nxt   = '0;
          state_nxt = S_DATA;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (!expire) begin
          baud_nxt = baud_cnt - BW'(1);
        end else begin
          shift_nxt = {shift_reg[UART_DBITS-2:0], rx_sync};
          baud_nxt  = BW'(BAUD_DIV - 1);
          if (bit_cnt == CW'(UART_DBITS - 1)) state_nxt = S_PARITY;
          else                                bit_nxt   = bit_cnt + CW'(1);
        end
      end
      S_PARITY: begin
        if (!expire) begin
          baud_nxt = baud_cnt - BW'(1);
        end else begin
          par_err_nxt = rx_sync ^ (^shift_reg);
          baud_nxt    = BW'(BAUD_DIV - 1);
          state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if (!expire) begin
          baud_nxt = baud_cnt - BW'(1);
        end else begin
          data_nxt  = shift_reg;
          perr_nxt  = par_err;
          ferr_nxt  = ~rx_sync;
          vld_nxt   = 1'b1;
          state_nxt = rx_sync ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_sync) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rs232_rx.sv
// Directed scoreboard bench for rs232_rx at 868 clocks per bit.
module tb_rs232_rx;

  localparam int BAUD = 868;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_vld, rx_perr, rx_ferr, rx_busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   vld_count  = 0;
  logic       prev_vld  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  rs232_rx #(.BAUD_DIV(BAUD)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .rx_perr (rx_perr),
    .rx_ferr (rx_ferr),
    .rx_busy (rx_busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: compare every delivered byte against the queued expectation.
  always @(negedge clk_sys) begin
    if (rx_vld) begin
      vld_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_vld", 8'd1, 8'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", rx_data, e.data);
        check("rx_perr", {7'd0, rx_perr}, {7'd0, e.perr});
        check("rx_ferr", {7'd0, rx_ferr}, {7'd0, e.ferr});
      end
      if (prev_vld) check("vld_width", 8'd2, 8'd1);
    end
    if (rst_n && !rx_vld && rx_data !== prev_data)
      check("data_hold", rx_data, prev_data);
    prev_vld  = rx_vld;
    prev_data = rx_data;
  end

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (BAUD) @(posedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = par ^ (^d);
    e.ferr = ~stop;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk_sys);
      n++;
    end
    check(tag, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk_sys);
    check({tag, "_data"}, rx_data, 8'h00);
    check({tag, "_vld"},  {7'd0, rx_vld},  8'd0);
    check({tag, "_perr"}, {7'd0, rx_perr}, 8'd0);
    check({tag, "_ferr"}, {7'd0, rx_ferr}, 8'd0);
    check({tag, "_busy"}, {7'd0, rx_busy}, 8'd0);
  endtask

  initial begin
    int vld_before;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(posedge clk_sys);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (20) @(posedge clk_sys);

    send_frame(8'h55, 1'b0, 1'b1);
    wait_drain("drain_55");

    send_frame(8'hAA, 1'b0, 1'b1);
    wait_drain("drain_aa");
    repeat (500) @(posedge clk_sys);
    send_frame(8'h01, 1'b1, 1'b1);
    wait_drain("drain_01");

    send_frame(8'h01, 1'b0, 1'b1);
    wait_drain("drain_01_perr");

    send_frame(8'h3C, 1'b0, 1'b0);
    wait_drain("drain_3c_ferr");
    repeat (2 * BAUD) @(posedge clk_sys);
    @(negedge clk_sys);
    check("busy_in_break", {7'd0, rx_busy}, 8'd1);
    uart_rx = 1'b1;
    repeat (10) @(posedge clk_sys);
    @(negedge clk_sys);
    check("busy_after_break", {7'd0, rx_busy}, 8'd0);
    repeat (20) @(posedge clk_sys);
    send_frame(8'hC3, 1'b0, 1'b1);
    wait_drain("drain_c3");

    vld_before = vld_count;
    uart_rx = 1'b0;
    repeat (100) @(posedge clk_sys);
    @(negedge clk_sys);
    check("busy_in_glitch", {7'd0, rx_busy}, 8'd1);
    repeat (200) @(posedge clk_sys);
    uart_rx = 1'b1;
    repeat (BAUD) @(posedge clk_sys);
    @(negedge clk_sys);
    check("busy_after_glitch", {7'd0, rx_busy}, 8'd0);
    check("glitch_no_vld", 8'(vld_count - vld_before), 8'd0);

    vld_before = vld_count;
    drive_bit(1'b0);
    for (int i = 7; i >= 4; i--) drive_bit(1'b1);
    uart_rx = 1'b0;
    repeat (BAUD / 2) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    check_reset_outputs("midrst");
    uart_rx = 1'b1;
    repeat (10) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (BAUD) @(posedge clk_sys);
    check("midrst_no_vld", 8'(vld_count - vld_before), 8'd0);
    send_frame(8'h0F, 1'b0, 1'b1);
    wait_drain("drain_0f");
    check("midrst_one_vld", 8'(vld_count - vld_before), 8'd1);

    repeat (20) @(posedge clk_sys);
    check("total_vld", 8'(vld_count), 8'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
